ss_a2d_mc: RTL and testbench
============================

// Module: ss_a2d_mc
// PURPOSE
// Multi-channel, parametrised single-slope A2D controller with integrated datapath.
// - Drives an external DAC ramp and analog channel mux; samples an asynchronous comparator (gt).
// - Accumulates 2**SMP_LOG2 ramp results per channel and reports the average.
// - Supports single-channel and scan (ch_in..NUM_CH-1) modes, abort, and ramp saturation.
// PARAMETERS
// DAC_W       8   DAC / result width in bits
// NUM_CH      4   analog channels on the mux (>=1)
// SMP_LOG2    3   log2 of samples averaged per conversion (0..6)
// SETTLE_CYC  4   mux settle cycles after every channel select (>=1)
// PORTS
// clk        in   1               clock
// rst        in   1               reset, asynchronous, active-high
// strt_cnv   in   1               start request; sampled only in IDLE
// ch_in      in   CH_W            first/only channel; CH_W = max(1,$clog2(NUM_CH)); values >=NUM_CH clamp to NUM_CH-1
// scan       in   1               1: convert ch_in..NUM_CH-1 sequentially; 0: ch_in only
// abort      in   1               synchronous abort; returns to IDLE
// gt         in   1               comparator (analog > DAC); asynchronous, double-flopped
// dac        out  DAC_W           DAC code (registered)
// ch_sel     out  CH_W            mux select (registered)
// busy       out  1               high in every state except IDLE
// result     out  DAC_W           averaged result; held until next cnv_cmplt
// result_ch  out  CH_W            channel that result belongs to
// sat        out  1               >=1 sample of this result hit full-scale without gt
// cnv_cmplt  out  1               one-cycle pulse; result/result_ch/sat valid same cycle
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, sync flops 0, counters 0, accumulator 0.
// - gt_s = gt after two flops. Captured code includes 2-count sync latency; offset is owned by calibration, not corrected here.
// - States: IDLE, SETTLE, RAMP, DISCHG, DONE.
// - IDLE: strt_cnv=1 -> latch scan, ch_sel<=clamp(ch_in), dac<=0, acc<=0, smp<=0, sat_acc<=0 -> SETTLE.
// - SETTLE: count SETTLE_CYC cycles, dac=0 -> RAMP.
// - RAMP, per cycle:
//   - gt_s=0 and dac!=MAX: dac++.
//   - gt_s=1 or dac==MAX: acc+=dac; sat_acc|=~gt_s; dac not incremented.
//     Then if smp==2**SMP_LOG2-1 -> DONE, else smp++ -> DISCHG.
// - DISCHG: dac<=0; stay while gt_s=1; gt_s=0 -> RAMP. Minimum 1 cycle.
// - DONE (1 cycle): cnv_cmplt=1, result=acc>>SMP_LOG2, result_ch=ch_sel, sat=sat_acc.
//   - scan && ch_sel!=NUM_CH-1: ch_sel++, clear acc/smp/sat_acc, dac=0 -> SETTLE.
//   - else -> IDLE.
// - Accumulator width DAC_W+SMP_LOG2 bits; never overflows. result is truncating shift.
// - abort (any state): next cycle IDLE, dac=0, busy=0, no cnv_cmplt; result/result_ch/sat keep last values.
//   - abort has priority over every transition, including DONE.
// - strt_cnv while busy: ignored, not queued.
// - abort and strt_cnv together in IDLE: abort wins, stay IDLE.
// - Async rst mid-conversion: immediate return to reset values.
// - Latency, single channel, no saturation:
//   1 (IDLE) + SETTLE_CYC + sum(ramp+dischg cycles) + 1 (DONE).
// - busy falls the cycle after the final cnv_cmplt.
// STRUCTURE
// - Package ss_a2d_pkg: state_t enum {IDLE,SETTLE,RAMP,DISCHG,DONE}; function clog2_min1.
// - Sub-module a2d_sync2: 2-flop synchroniser, async active-high reset to 0. Reused for gt.
// - One always_ff for state and datapath registers; one always_comb for next_state and controls, all defaulted.
// TESTING (DAC_W=8, NUM_CH=4, SMP_LOG2=3, SETTLE_CYC=4; gt model: gt=1 when dac>=thr)
// 1. rst=1 mid-RAMP -> all outputs 0 within same cycle; after release, busy=0 until strt_cnv.
// 2. ch_in=2, scan=0, thr=0x40 -> single cnv_cmplt: result=0x42, result_ch=2, sat=0; busy drops next cycle.
// 3. ch_in=1, gt tied 0 -> result=0xFF, sat=1, result_ch=1; dac never exceeds 0xFF.
// 4. ch_in=0, scan=1, thr 0x10/0x20/0x30/0x40 per channel ->
//    4 pulses: (0x12,ch0), (0x22,ch1), (0x32,ch2), (0x42,ch3); ch_sel steps 0..3.
// 5. abort during 4th RAMP -> IDLE next cycle, dac=0, no cnv_cmplt, result unchanged;
//    then strt_cnv on ch3, thr=0x40 -> result=0x42.
// 6. strt_cnv pulsed while busy, plus ch_in=7 (clamps to 3) -> extra pulse ignored; one conversion; result_ch=3.

Source files
------------

// File: rtl/ss_a2d_pkg.sv
// Shared types and helpers for the single-slope A2D controller.
//   state_t    : controller states (also exported on the debug port)
//   clog2_min1 : $clog2 that never returns less than 1, for select widths
package ss_a2d_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    RAMP   = 3'd2,
    DISCHG = 3'd3,
    DONE   = 3'd4
  } state_t;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ss_a2d_mc_if.sv
// Bundle of all non-clock signals of the single-slope A2D controller.
//   master : the user side (drives strt_cnv/ch_in/scan/abort) plus the
//            analog front end (drives the comparator output gt)
//   slave  : the controller itself
// Handshake: strt_cnv is a level request that is only looked at while the
// controller is idle (busy=0); requests while busy are dropped, not queued.
// cnv_cmplt is a one-cycle valid strobe with no back-pressure; result,
// result_ch and sat are valid in that cycle and hold until the next strobe.
// state_dbg exposes the controller state for observation.
interface ss_a2d_mc_if #(
  parameter int DAC_W  = 8,
  parameter int NUM_CH = 4
);
  import ss_a2d_pkg::*;

  localparam int CH_W = clog2_min1(NUM_CH);

  logic              strt_cnv;
  logic [CH_W-1:0]   ch_in;
  logic              scan;
  logic              abort;
  logic              gt;
  logic [DAC_W-1:0]  dac;
  logic [CH_W-1:0]   ch_sel;
  logic              busy;
  logic [DAC_W-1:0]  result;
  logic [CH_W-1:0]   result_ch;
  logic              sat;
  logic              cnv_cmplt;
  state_t            state_dbg;

  modport master (
    output strt_cnv, ch_in, scan, abort, gt,
    input  dac, ch_sel, busy, result, result_ch, sat, cnv_cmplt, state_dbg
  );

  modport slave (
    input  strt_cnv, ch_in, scan, abort, gt,
    output dac, ch_sel, busy, result, result_ch, sat, cnv_cmplt, state_dbg
  );

endinterface

// File: rtl/a2d_sync2.sv
// Two-flop synchroniser for a single asynchronous input.
//   clk, rst : clock, asynchronous active-high reset (flops clear to 0)
//   d_i      : asynchronous input
//   q_o      : synchronised output, two clocks behind d_i
module a2d_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ss_a2d_mc.sv
// Multi-channel single-slope A2D controller.
// Drives a DAC ramp and the analog mux, watches the synchronised comparator,
// accumulates 2**SMP_LOG2 ramp codes per channel and reports their average.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : ss_a2d_mc_if.slave (request/abort in, comparator in,
//              dac/ch_sel out, busy/result/result_ch/sat/cnv_cmplt out)
// Captured codes include the two-clock comparator sync latency; that offset
// is left for calibration to remove.
module ss_a2d_mc
  import ss_a2d_pkg::*;
#(
  parameter int DAC_W      = 8,
  parameter int NUM_CH     = 4,
  parameter int SMP_LOG2   = 3,
  parameter int SETTLE_CYC = 4
) (
  input  logic        clk,
  input  logic        rst,
  ss_a2d_mc_if.slave  bus
);

  localparam int CH_W  = clog2_min1(NUM_CH);
  localparam int ACC_W = DAC_W + SMP_LOG2;
  localparam int SMP_W = (SMP_LOG2 < 1) ? 1 : SMP_LOG2;
  localparam int SET_W = clog2_min1(SETTLE_CYC);

  localparam logic [DAC_W-1:0] DAC_MAX  = '1;
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'((1 << SMP_LOG2) - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);

  state_t             state_q,     state_d;
  logic [DAC_W-1:0]   dac_q,       dac_d;
  logic [CH_W-1:0]    ch_sel_q,    ch_sel_d;
  logic               scan_q,      scan_d;
  logic [ACC_W-1:0]   acc_q,       acc_d;
  logic [SMP_W-1:0]   smp_q,       smp_d;
  logic               sat_acc_q,   sat_acc_d;
  logic [SET_W-1:0]   set_cnt_q,   set_cnt_d;
  logic [DAC_W-1:0]   result_q,    result_d;
  logic [CH_W-1:0]    result_ch_q, result_ch_d;
  logic               sat_q,       sat_d;

  logic               gt_s;
  logic [CH_W-1:0]    ch_clamp;

  a2d_sync2 u_gt_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.gt),
    .q_o (gt_s)
  );

  // Out-of-range channel requests select the last real channel. Compared as
  // int so the test stays meaningful when NUM_CH fills the select width.
  assign ch_clamp = (int'(bus.ch_in) >= NUM_CH) ? CH_LAST : bus.ch_in;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      dac_q       <= '0;
      ch_sel_q    <= '0;
      scan_q      <= 1'b0;
      acc_q       <= '0;
      smp_q       <= '0;
      sat_acc_q   <= 1'b0;
      set_cnt_q   <= '0;
      result_q    <= '0;
      result_ch_q <= '0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dac_q       <= dac_d;
      ch_sel_q    <= ch_sel_d;
      scan_q      <= scan_d;
      acc_q       <= acc_d;
      smp_q       <= smp_d;
      sat_acc_q   <= sat_acc_d;
      set_cnt_q   <= set_cnt_d;
      result_q    <= result_d;
      result_ch_q <= result_ch_d;
      sat_q       <= sat_d;
    end
  end

  // Next state and datapath controls
  always_comb begin
    state_d     = state_q;
    dac_d       = dac_q;
    ch_sel_d    = ch_sel_q;
    scan_d      = scan_q;
    acc_d       = acc_q;
    smp_d       = smp_q;
    sat_acc_d   = sat_acc_q;
    set_cnt_d   = set_cnt_q;
    result_d    = result_q;
    result_ch_d = result_ch_q;
    sat_d       = sat_q;

    if (bus.abort) begin
      // Abort beats every transition, including the DONE report.
      state_d   = IDLE;
      dac_d     = '0;
      set_cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.strt_cnv) begin
            state_d   = SETTLE;
            scan_d    = bus.scan;
            ch_sel_d  = ch_clamp;
            dac_d     = '0;
            acc_d     = '0;
            smp_d     = '0;
            sat_acc_d = 1'b0;
            set_cnt_d = '0;
          end
        end
        SETTLE: begin
          dac_d = '0;
          if (set_cnt_q == SET_LAST) begin
            state_d   = RAMP;
            set_cnt_d = '0;
          end else begin
            set_cnt_d = set_cnt_q + 1'b1;
          end
        end
        RAMP: begin
          if (!gt_s && (dac_q != DAC_MAX)) begin
            dac_d = dac_q + 1'b1;
          end else begin
            // A full-scale stop without gt marks the sample as saturated.
            acc_d     = acc_q + ACC_W'(dac_q);
            sat_acc_d = sat_acc_q | ~gt_s;
            if (smp_q == SMP_LAST) begin
              state_d = DONE;
            end else begin
              smp_d   = smp_q + 1'b1;
              state_d = DISCHG;
            end
          end
        end
        DISCHG: begin
          // Hold the ramp at zero until the comparator has dropped, so the
          // next ramp does not start from a stale gt.
          dac_d = '0;
          if (!gt_s) state_d = RAMP;
        end
        DONE: begin
          result_d    = DAC_W'(acc_q >> SMP_LOG2);
          result_ch_d = ch_sel_q;
          sat_d       = sat_acc_q;
          dac_d       = '0;
          if (scan_q && (ch_sel_q != CH_LAST)) begin
            ch_sel_d  = ch_sel_q + 1'b1;
            acc_d     = '0;
            smp_d     = '0;
            sat_acc_d = 1'b0;
            set_cnt_d = '0;
            state_d   = SETTLE;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs. result_d already equals the fresh average during an
  // un-aborted DONE cycle and the held value otherwise.
  always_comb begin
    bus.busy      = (state_q != IDLE);
    bus.cnv_cmplt = (state_q == DONE) && !bus.abort;
    bus.result    = result_d;
    bus.result_ch = result_ch_d;
    bus.sat       = sat_d;
    bus.dac       = dac_q;
    bus.ch_sel    = ch_sel_q;
    bus.state_dbg = state_q;
  end

endmodule

// File: tb/tb_ss_a2d_mc.sv
// Bench for ss_a2d_mc: directed scenarios plus random trials, with a
// scoreboard queue filled at request time and drained by a monitor.
module tb_ss_a2d_mc;
  import ss_a2d_pkg::*;

  localparam int DAC_W      = 8;
  localparam int NUM_CH     = 4;
  localparam int SMP_LOG2   = 3;
  localparam int SETTLE_CYC = 4;
  localparam int CH_W       = 2;
  localparam int EW         = DAC_W + CH_W + 2;
  localparam int NEVER      = 'h1FF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ss_a2d_mc_if #(.DAC_W(DAC_W), .NUM_CH(NUM_CH)) bus ();

  ss_a2d_mc #(
    .DAC_W(DAC_W), .NUM_CH(NUM_CH), .SMP_LOG2(SMP_LOG2), .SETTLE_CYC(SETTLE_CYC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Analog model: each channel has its own threshold; comparator is high
  // while the DAC is at or above it.
  int thr [NUM_CH];
  assign bus.gt = (int'(bus.dac) >= thr[bus.ch_sel]);

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  int last_res = 0;
  // entry = {last_of_run, sat, ch, result}
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One ramp sample from the spec's rules: gt is seen two clocks late, so
  // the ramp stops two codes above the threshold; full scale stops it
  // otherwise and counts as saturated unless gt was already seen there.
  function automatic logic [DAC_W:0] ref_sample(input int t);
    int code;
    code = t + 2;
    if (code <= 255) return {1'b0, DAC_W'(code)};
    return {1'b1, 8'hFF};
  endfunction

  task automatic expect_conv(input int ch, input bit sc);
    int c0, c1, s, res;
    logic any_sat;
    logic [DAC_W:0] smp;
    logic [EW-1:0] ent;
    c0 = ch % (1 << CH_W);
    if (c0 >= NUM_CH) c0 = NUM_CH - 1;
    c1 = sc ? NUM_CH - 1 : c0;
    for (int c = c0; c <= c1; c++) begin
      s = 0;
      any_sat = 1'b0;
      for (int k = 0; k < (1 << SMP_LOG2); k++) begin
        smp = ref_sample(thr[c]);
        s += int'(smp[DAC_W-1:0]);
        any_sat |= smp[DAC_W];
      end
      res = s / (1 << SMP_LOG2);
      ent = {(c == c1), any_sat, CH_W'(c), DAC_W'(res)};
      exp_q.push_back(ent);
      last_res = res;
    end
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [EW-1:0] e;
    logic pend_last;
    logic pend_next;
    int   next_ch;
    int   held_res;
    pend_last = 1'b0;
    pend_next = 1'b0;
    next_ch   = 0;
    held_res  = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend_last = 1'b0;
        pend_next = 1'b0;
      end else begin
        if (pend_last) begin
          check("busy_after_last", int'(bus.busy), 0);
          check("result_held", int'(bus.result), held_res);
          pend_last = 1'b0;
        end
        if (pend_next) begin
          check("busy_between_ch", int'(bus.busy), 1);
          check("ch_sel_step", int'(bus.ch_sel), next_ch);
          pend_next = 1'b0;
        end
        if (bus.cnv_cmplt) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_cnv_cmplt: result=0x%0h ch=%0d, none expected at %0t",
                     bus.result, bus.result_ch, $time);
          end else begin
            e = exp_q.pop_front();
            check("result", int'(bus.result), int'(e[DAC_W-1:0]));
            check("result_ch", int'(bus.result_ch), int'(e[DAC_W+CH_W-1:DAC_W]));
            check("sat", int'(bus.sat), int'(e[EW-2]));
            held_res = int'(e[DAC_W-1:0]);
            if (e[EW-1]) pend_last = 1'b1;
            else begin
              pend_next = 1'b1;
              next_ch   = int'(e[DAC_W+CH_W-1:DAC_W]) + 1;
            end
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_conv(input int ch, input bit sc);
    @(negedge clk);
    bus.ch_in    = CH_W'(ch);
    bus.scan     = sc;
    bus.strt_cnv = 1'b1;
    @(negedge clk);
    bus.strt_cnv = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (!bus.busy) done = 1'b1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: busy still 1 after %0d cycles, required 0", name, budget);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_busy"}, int'(bus.busy), 0);
    check({name, "_dac"}, int'(bus.dac), 0);
    check({name, "_cnv_cmplt"}, int'(bus.cnv_cmplt), 0);
    check({name, "_state"}, int'(bus.state_dbg), int'(IDLE));
  endtask

  // ---------------- watchdog ----------------
  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin : driver
    int drops;
    int prev_dac;
    int seen_busy;
    int ch;
    bit sc;
    bus.strt_cnv = 1'b0;
    bus.ch_in    = '0;
    bus.scan     = 1'b0;
    bus.abort    = 1'b0;
    for (int c = 0; c < NUM_CH; c++) thr[c] = NEVER;

    // Power-on reset values
    repeat (3) @(negedge clk);
    check_idle_outputs("por");
    check("por_result", int'(bus.result), 0);
    check("por_ch_sel", int'(bus.ch_sel), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single channel 2, threshold 0x40
    thr[2] = 'h40;
    expect_conv(2, 1'b0);
    start_conv(2, 1'b0);
    wait_idle("single_ch2", 20000);

    // Channel 1 with comparator never tripping: full-scale, saturated
    thr[1] = NEVER;
    expect_conv(1, 1'b0);
    start_conv(1, 1'b0);
    wait_idle("sat_ch1", 20000);

    // Asynchronous reset in the middle of a ramp
    thr[0] = 'h80;
    start_conv(0, 1'b0);
    repeat (40) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_idle_outputs("mid_rst");
    check("mid_rst_result", int'(bus.result), 0);
    check("mid_rst_result_ch", int'(bus.result_ch), 0);
    check("mid_rst_sat", int'(bus.sat), 0);
    check("mid_rst_ch_sel", int'(bus.ch_sel), 0);
    last_res = 0;
    @(negedge clk);
    rst = 1'b0;
    seen_busy = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.busy) seen_busy++;
    end
    check("post_rst_busy_cycles", seen_busy, 0);

    // Scan from channel 0 with a different threshold per channel
    thr[0] = 'h10; thr[1] = 'h20; thr[2] = 'h30; thr[3] = 'h40;
    expect_conv(0, 1'b1);
    start_conv(0, 1'b1);
    wait_idle("scan", 40000);

    // Abort during the fourth ramp of a channel-3 conversion
    thr[3] = 'h40;
    start_conv(3, 1'b0);
    drops = 0;
    prev_dac = 0;
    for (int i = 0; i < 3000 && drops < 3; i++) begin
      @(negedge clk);
      if (prev_dac != 0 && bus.dac == 0) drops++;
      prev_dac = int'(bus.dac);
    end
    check("abort_ramp_count", drops, 3);
    repeat (20) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check_idle_outputs("abort");
    check("abort_result_kept", int'(bus.result), last_res);
    repeat (5) @(negedge clk);
    check("abort_stays_idle", int'(bus.busy), 0);

    // abort together with strt_cnv in IDLE: stays idle
    @(negedge clk);
    bus.ch_in = 2'd1;
    bus.strt_cnv = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.strt_cnv = 1'b0;
    bus.abort = 1'b0;
    check("abort_wins_busy", int'(bus.busy), 0);

    // Restart on channel 3 after the abort
    expect_conv(3, 1'b0);
    start_conv(3, 1'b0);
    wait_idle("after_abort", 20000);

    // Request of 7 lands on channel 3; a second request while busy is dropped
    thr[3] = 'h25;
    expect_conv(7, 1'b0);
    start_conv(7, 1'b0);
    repeat (10) @(negedge clk);
    bus.ch_in = 2'd0;
    bus.scan = 1'b1;
    bus.strt_cnv = 1'b1;
    @(negedge clk);
    bus.strt_cnv = 1'b0;
    bus.scan = 1'b0;
    wait_idle("busy_ignore", 20000);
    repeat (5) @(negedge clk);
    check("busy_ignore_idle", int'(bus.busy), 0);

    // Random trials
    for (int t = 0; t < 5; t++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, 7) == 0) thr[c] = int'($urandom_range('hF8, NEVER));
        else thr[c] = int'($urandom_range(1, 'h60));
      end
      ch = int'($urandom_range(0, NUM_CH - 1));
      sc = 1'($urandom_range(0, 1));
      expect_conv(ch, sc);
      start_conv(ch, sc);
      wait_idle("random", 40000);
    end

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
